// File: rtl/alarm_key_entry_if.sv
// Keypad-side bus of the alarm clock key entry block: key/button inputs,
// buffered digits, load strobes and display-select flags.
interface alarm_key_entry_if;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key_buffer_ms_hr;
  logic [3:0] key_buffer_ls_hr;
  logic [3:0] key_buffer_ms_min;
  logic [3:0] key_buffer_ls_min;
  logic       load_new_alarm;
  logic       load_new_time;
  logic       show_new_time;
  logic       show_alarm;

  // master drives the keypad/buttons; slave is the key entry block
  modport master (
    output one_second, key_valid, key, alarm_button, time_button,
    input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    input  load_new_alarm, load_new_time, show_new_time, show_alarm
  );

  modport slave (
    input  one_second, key_valid, key, alarm_button, time_button,
    output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    output load_new_alarm, load_new_time, show_new_time, show_alarm
  );
endinterface

// File: rtl/alarm_key_entry.sv
// Alarm clock keypad front end: shifts decimal digits into an HH:MM buffer and
// sequences alarm/time loads, display selection and stale-entry timeout.
module alarm_key_entry #(
  parameter int unsigned TIMEOUT_SECONDS = 10
) (
  input  logic              clock,
  input  logic              reset,
  alarm_key_entry_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD_ALARM,
    S_LOAD_TIME,
    S_WAIT_RELEASE,
    S_SHOW_ALARM
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_SECONDS - 1);
  localparam logic [2:0] FULL_COUNT   = 3'd4;

  state_e      state_q, state_d;
  logic [15:0] buffer_q, buffer_d;   // {ms_hr, ls_hr, ms_min, ls_min}
  logic [2:0]  count_q, count_d;
  logic [7:0]  timer_q, timer_d;

  logic digit_ok;
  logic any_button;

  assign digit_ok   = bus.key_valid && (bus.key <= 4'd9);
  assign any_button = bus.alarm_button || bus.time_button;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    timer_d  = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          buffer_d = {12'h000, bus.key};
          count_d  = 3'd1;
          timer_d  = 8'd0;
          state_d  = S_ENTRY;
        end else if (bus.alarm_button) begin
          state_d = S_SHOW_ALARM;
        end
      end

      S_ENTRY: begin
        if (any_button) begin
          timer_d = 8'd0;
          if (count_q == FULL_COUNT) begin
            state_d = bus.alarm_button ? S_LOAD_ALARM : S_LOAD_TIME;
          end else begin
            // Short entry aborts; parking in WAIT_RELEASE keeps a still-held
            // alarm button from dropping straight into SHOW_ALARM.
            buffer_d = 16'h0000;
            count_d  = 3'd0;
            state_d  = S_WAIT_RELEASE;
          end
        end else if (digit_ok) begin
          buffer_d = {buffer_q[11:0], bus.key};
          count_d  = (count_q == FULL_COUNT) ? FULL_COUNT : count_q + 3'd1;
          timer_d  = 8'd0;
        end else if (bus.one_second) begin
          if (timer_q == TIMEOUT_LAST) begin
            buffer_d = 16'h0000;
            count_d  = 3'd0;
            timer_d  = 8'd0;
            state_d  = S_IDLE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end

      S_LOAD_ALARM, S_LOAD_TIME: begin
        state_d = S_WAIT_RELEASE;
      end

      S_WAIT_RELEASE: begin
        if (!any_button) begin
          buffer_d = 16'h0000;
          count_d  = 3'd0;
          state_d  = S_IDLE;
        end
      end

      S_SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      buffer_q <= 16'h0000;
      count_q  <= 3'd0;
      timer_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
    end
  end

  assign bus.key_buffer_ms_hr  = buffer_q[15:12];
  assign bus.key_buffer_ls_hr  = buffer_q[11:8];
  assign bus.key_buffer_ms_min = buffer_q[7:4];
  assign bus.key_buffer_ls_min = buffer_q[3:0];

  assign bus.load_new_alarm = (state_q == S_LOAD_ALARM);
  assign bus.load_new_time  = (state_q == S_LOAD_TIME);
  assign bus.show_new_time  = (state_q == S_ENTRY);
  assign bus.show_alarm     = (state_q == S_SHOW_ALARM);

endmodule

// File: tb/tb_alarm_key_entry.sv
// Directed bench for alarm_key_entry: digit entry, loads, aborts, timeout,
// ignored keys, alarm display and reset during a load strobe.
module tb_alarm_key_entry;

  localparam int T = 10;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  alarm_key_entry_if bus ();

  alarm_key_entry #(.TIMEOUT_SECONDS(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {load_new_alarm, load_new_time, show_new_time, show_alarm}
  function automatic logic [15:0] flags();
    return {12'h000, bus.load_new_alarm, bus.load_new_time, bus.show_new_time, bus.show_alarm};
  endfunction

  function automatic logic [15:0] buffer();
    return {bus.key_buffer_ms_hr, bus.key_buffer_ls_hr, bus.key_buffer_ms_min, bus.key_buffer_ls_min};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key       = k;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic second();
    bus.one_second = 1'b1;
    tick();
    bus.one_second = 1'b0;
    tick();
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.one_second   = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key          = 4'd0;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_flags", flags(), 16'h0000);
    check("reset_buffer", buffer(), 16'h0000);

    for (int i = 0; i < 5; i++) begin
      second();
      check("idle_flags", flags(), 16'h0000);
      check("idle_buffer", buffer(), 16'h0000);
    end

    // Alarm load of 07:30
    press(4'd0);
    check("entry_flags", flags(), 16'h0002);
    check("entry_first", buffer(), 16'h0000);
    press(4'd7);
    press(4'd3);
    press(4'd0);
    check("alarm_buffer", buffer(), 16'h0730);
    bus.alarm_button = 1'b1;
    tick();
    check("alarm_strobe", flags(), 16'h0008);
    check("alarm_strobe_buffer", buffer(), 16'h0730);
    tick();
    check("alarm_strobe_end", flags(), 16'h0000);
    bus.alarm_button = 1'b0;
    tick();
    check("alarm_done_flags", flags(), 16'h0000);
    check("alarm_done_buffer", buffer(), 16'h0000);

    // Five digits, oldest dropped, then time load
    press(4'd1);
    press(4'd2);
    press(4'd4);
    press(4'd5);
    press(4'd9);
    check("time_buffer", buffer(), 16'h2459);
    bus.time_button = 1'b1;
    tick();
    check("time_strobe", flags(), 16'h0004);
    tick();
    check("time_strobe_end", flags(), 16'h0000);
    bus.time_button = 1'b0;
    tick();
    check("time_done_buffer", buffer(), 16'h0000);

    // Short entry aborted by a held alarm button
    press(4'd1);
    press(4'd2);
    check("short_buffer", buffer(), 16'h0012);
    bus.alarm_button = 1'b1;
    tick();
    check("abort_flags", flags(), 16'h0000);
    check("abort_buffer", buffer(), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_held", flags(), 16'h0000);
    end
    bus.alarm_button = 1'b0;
    tick();
    check("abort_release", flags(), 16'h0000);

    // Alarm display while the button is held in IDLE
    bus.alarm_button = 1'b1;
    tick();
    check("show_alarm_on", flags(), 16'h0001);
    tick();
    check("show_alarm_hold", flags(), 16'h0001);
    bus.alarm_button = 1'b0;
    tick();
    check("show_alarm_off", flags(), 16'h0000);

    // Timeout after T idle seconds
    press(4'd4);
    check("timeout_start", buffer(), 16'h0004);
    for (int i = 0; i < T - 1; i++) begin
      second();
      check("timeout_wait", flags(), 16'h0002);
    end
    bus.one_second = 1'b1;
    tick();
    bus.one_second = 1'b0;
    check("timeout_flags", flags(), 16'h0000);
    check("timeout_buffer", buffer(), 16'h0000);

    // Digit on the final tick wins and restarts the timer
    press(4'd4);
    for (int i = 0; i < T - 1; i++) second();
    bus.one_second = 1'b1;
    bus.key        = 4'd5;
    bus.key_valid  = 1'b1;
    tick();
    bus.one_second = 1'b0;
    bus.key_valid  = 1'b0;
    check("race_flags", flags(), 16'h0002);
    check("race_buffer", buffer(), 16'h0045);
    for (int i = 0; i < T - 1; i++) second();
    check("restart_wait", flags(), 16'h0002);
    bus.one_second = 1'b1;
    tick();
    bus.one_second = 1'b0;
    check("restart_timeout", flags(), 16'h0000);
    check("restart_buffer", buffer(), 16'h0000);

    // Non-digit keys ignored in IDLE and ENTRY
    press(4'd11);
    check("key11_flags", flags(), 16'h0000);
    check("key11_buffer", buffer(), 16'h0000);
    press(4'd3);
    press(4'd12);
    check("key12_buffer", buffer(), 16'h0003);
    check("key12_flags", flags(), 16'h0002);
    bus.time_button = 1'b1;
    tick();
    check("time_abort_buffer", buffer(), 16'h0000);
    check("time_abort_flags", flags(), 16'h0000);
    bus.time_button = 1'b0;
    tick();

    // Both buttons with a full buffer: alarm wins
    press(4'd0);
    press(4'd6);
    press(4'd4);
    press(4'd5);
    bus.alarm_button = 1'b1;
    bus.time_button  = 1'b1;
    tick();
    check("both_strobe", flags(), 16'h0008);
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    tick();
    tick();
    check("both_done", flags(), 16'h0000);

    // Reset during the alarm load strobe
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    bus.alarm_button = 1'b1;
    tick();
    check("pre_reset_strobe", flags(), 16'h0008);
    reset            = 1'b1;
    bus.alarm_button = 1'b0;
    tick();
    check("mid_reset_flags", flags(), 16'h0000);
    check("mid_reset_buffer", buffer(), 16'h0000);
    reset = 1'b0;
    tick();
    check("post_reset_flags", flags(), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
